// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clock divider bank.
package clk_div_pkg;

    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 25;

    // Channel i occupies bits [i*CNT_W +: CNT_W]; channel 0 is the fast bit clock.
    localparam logic [NUM_CH_DEF*CNT_W_DEF-1:0] DIV_INIT_DEF = {25'd2500, 25'd25};

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, 50% output and toggle strobe.
module clk_div_chan #(
    parameter int unsigned      CNT_W   = 25,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             idle;
    logic             term;

    assign idle = sync || !en;
    assign term = (cnt_q == act_q);

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        out_d  = out_q;
        tick_d = 1'b0;
        pend_d = pend_q;

        if (wr) begin
            shd_d  = wdata;
            pend_d = 1'b1;
        end

        if (idle) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Divisor swaps only at a cnt==0 boundary so no half-period is cut short.
        if (idle || term) begin
            act_d  = wr ? wdata : shd_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q  <= '0;
            act_q  <= DIV_RST;
            shd_q  <= DIV_RST;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with glitch-free divisor reprogramming.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned               NUM_CH   = NUM_CH_DEF,
    parameter int unsigned               CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = DIV_INIT_DEF,
    localparam int unsigned              CH_W     = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    // Out-of-range channel indices are possible when NUM_CH is not a power of two.
    logic ch_ok;
    assign ch_ok = (32'(cfg_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && ch_ok && (32'(cfg_ch) == i);

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk     (clk),
            .RST     (RST),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr),
            .wdata   (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: per-cycle scoreboard plus directed timing checks.
module tb_clk_div_bank;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  en = 2'b11;
    logic        sync = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_ch = 1'b0;
    logic [24:0] cfg_div = '0;
    logic [1:0]  clk_out, tick, cfg_pending;

    // Second instance with a non-power-of-two channel count to exercise index rejection.
    logic        cfg_we3 = 1'b0;
    logic [1:0]  cfg_ch3 = '0;
    logic [7:0]  cfg_div3 = '0;
    logic [2:0]  clk_out3, tick3, pend3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_div_bank u_dut (
        .clk         (clk),
        .RST         (RST),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    clk_div_bank #(
        .NUM_CH   (3),
        .CNT_W    (8),
        .DIV_INIT ({8'd5, 8'd4, 8'd3})
    ) u_dut3 (
        .clk         (clk),
        .RST         (RST),
        .en          (3'b111),
        .sync        (1'b0),
        .cfg_we      (cfg_we3),
        .cfg_ch      (cfg_ch3),
        .cfg_div     (cfg_div3),
        .clk_out     (clk_out3),
        .tick        (tick3),
        .cfg_pending (pend3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model, advanced once per rising edge from the same inputs the DUT sees.
    logic [24:0] m_cnt [2];
    logic [24:0] m_act [2];
    logic [24:0] m_shd [2];
    logic [1:0]  m_out, m_tick, m_pend;
    logic [5:0]  sb_q [$];

    function automatic logic [24:0] init_div(input int ch);
        return (ch == 0) ? 25'd25 : 25'd2500;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic hit;
            hit = cfg_we && (int'(cfg_ch) == i);
            m_tick[i] = 1'b0;
            if (RST) begin
                m_cnt[i]  = '0;
                m_out[i]  = 1'b0;
                m_pend[i] = 1'b0;
                m_act[i]  = init_div(i);
                m_shd[i]  = init_div(i);
            end else if (sync || !en[i] || m_cnt[i] == m_act[i]) begin
                if (!sync && en[i]) begin
                    m_out[i]  = ~m_out[i];
                    m_tick[i] = 1'b1;
                end else begin
                    m_out[i] = 1'b0;
                end
                m_cnt[i]  = '0;
                if (hit) m_shd[i] = cfg_div;
                m_act[i]  = m_shd[i];
                m_pend[i] = 1'b0;
            end else begin
                m_cnt[i] = m_cnt[i] + 25'd1;
                if (hit) begin
                    m_shd[i]  = cfg_div;
                    m_pend[i] = 1'b1;
                end
            end
        end
        sb_q.push_back({m_out, m_tick, m_pend});
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (sb_q.size() > 0) check("sb", {clk_out, tick, cfg_pending}, sb_q.pop_front());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        en = 2'b11;
        sync = 1'b0;
        cfg_we = 1'b0;
        repeat (3) step();
        RST = 1'b0;
    endtask

    // Steps until clk_out[ch] reaches lvl; returns the step count (budget on timeout).
    task automatic wait_edge(input int ch, input logic lvl, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (clk_out[ch] === lvl) break;
        end
    endtask

    task automatic write_cfg(input logic ch, input logic [24:0] d);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_div = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;

        // Reset defaults
        do_reset();
        check("rst_out", clk_out, 2'b00);
        check("rst_pend", cfg_pending, 2'b00);
        wait_edge(0, 1'b1, 100, n);
        check("t1_first_rise0", n, 26);
        check("t1_tick_rise", tick[0], 1'b1);
        wait_edge(0, 1'b0, 100, n);
        check("t1_half0_lo", n, 26);
        wait_edge(0, 1'b1, 100, n);
        check("t1_half0_hi", n, 26);
        do_reset();
        wait_edge(1, 1'b1, 3000, n);
        check("t1_first_rise1", n, 2501);
        wait_edge(1, 1'b0, 3000, n);
        check("t1_half1_a", n, 2501);
        wait_edge(1, 1'b1, 3000, n);
        check("t1_half1_b", n, 2501);

        // Mid-period reprogram
        do_reset();
        repeat (10) step();
        write_cfg(1'b0, 25'd3);
        check("t2_pend_set", cfg_pending[0], 1'b1);
        wait_edge(0, 1'b1, 100, n);
        check("t2_rise_kept", n, 15);
        check("t2_pend_clr", cfg_pending[0], 1'b0);
        wait_edge(0, 1'b0, 100, n);
        check("t2_half_a", n, 4);
        wait_edge(0, 1'b1, 100, n);
        check("t2_half_b", n, 4);

        // Same-cycle write at terminal count
        do_reset();
        repeat (25) step();
        write_cfg(1'b0, 25'd7);
        check("t3_rise", clk_out[0], 1'b1);
        check("t3_pend", cfg_pending[0], 1'b0);
        wait_edge(0, 1'b0, 100, n);
        check("t3_half", n, 8);

        // Sync realigns both channels
        do_reset();
        repeat (30) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t4_out", clk_out, 2'b00);
        check("t4_tick", tick, 2'b00);
        wait_edge(0, 1'b1, 100, n);
        check("t4_rise0", n, 26);
        repeat (40) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        wait_edge(1, 1'b1, 3000, n);
        check("t4_rise1", n, 2501);

        // Disable / re-enable
        do_reset();
        wait_edge(0, 1'b1, 100, n);
        en = 2'b10;
        step();
        check("t5_off_out", clk_out[0], 1'b0);
        check("t5_off_tick", tick[0], 1'b0);
        write_cfg(1'b0, 25'd1);
        check("t5_off_pend", cfg_pending[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_off_quiet", {clk_out[0], tick[0]}, 2'b00);
        end
        en = 2'b11;
        wait_edge(0, 1'b1, 20, n);
        check("t5_reen_rise", n, 2);
        wait_edge(0, 1'b0, 20, n);
        check("t5_reen_fall", n, 2);

        // Bad channel index, then reset with a write pending
        do_reset();
        step();
        cfg_we3 = 1'b1;
        cfg_ch3 = 2'd3;
        cfg_div3 = 8'd9;
        step();
        check("t6_bad_ch", pend3, 3'b000);
        cfg_ch3 = 2'd2;
        step();
        cfg_we3 = 1'b0;
        check("t6_good_ch", pend3, 3'b100);
        write_cfg(1'b1, 25'd100);
        check("t6_pend1", cfg_pending[1], 1'b1);
        wait_edge(0, 1'b1, 100, n);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("t6_rst_pend", cfg_pending, 2'b00);
        check("t6_rst_out", clk_out, 2'b00);
        check("t6_rst_tick", tick, 2'b00);
        wait_edge(1, 1'b1, 3000, n);
        check("t6_div_restored", n, 2501);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
